dw_window_scheduler: RTL and testbench

Sequencer for the depthwise-conv pixel window. After the layer window is buffered, it drives the pixel window's control inputs: `init_buffer`, `depthwise_en`, `first_cycle` and `depth_channel_sel`. It steps output pixels in raster order and channel groups within each pixel, and tells the DSU when `output_feature` is valid. It sits between the layer-level controller (start/done) and the pixel_window/DSU pair.

---
 rtl/dw_pkg.sv | 30 +++
 rtl/dw_window_scheduler_if.sv | 35 +++
 rtl/dw_pixel_counter.sv | 39 +++
 rtl/dw_window_scheduler.sv | 115 +++++++++++
 tb/tb_dw_window_scheduler.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dw_pkg.sv
// Shared types and constants for the depthwise-conv window scheduler.
// Holds the FSM state encoding and the last-channel-group test.
package dw_pkg;

  localparam int CHANNEL_PARALLELISM = 4;
  localparam int MAX_CHANNEL         = 32;
  localparam int PADDING             = 1;
  localparam int CNT_W               = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_FILL,
    S_WAIT_FIRST,
    S_ISSUE,
    S_WAIT_WIN,
    S_DONE
  } state_t;

  // True when the group at `sel` is the final one for `channel`. The ">=" form
  // also terminates a pixel if an illegal non-multiple channel count slips in.
  function automatic logic last_group(input logic [CNT_W-1:0] sel,
                                      input logic [CNT_W-1:0] channel,
                                      input int unsigned      step = CHANNEL_PARALLELISM);
    logic [CNT_W:0] nxt;
    nxt = {1'b0, sel} + (CNT_W+1)'(step);
    return nxt >= {1'b0, channel};
  endfunction

endpackage

// File: rtl/dw_window_scheduler_if.sv
// Control bundle between the layer controller / pixel window / DSU and the
// scheduler. The scheduler takes the slave side.
interface dw_window_scheduler_if;
  import dw_pkg::*;

  logic             start;
  logic [CNT_W-1:0] input_size;
  logic [CNT_W-1:0] channel;
  logic             init_buffer_done;
  logic             win_first;
  logic             win_done;
  logic             dsu_ready;

  logic             init_buffer;
  logic             depthwise_en;
  logic             first_cycle;
  logic [CNT_W-1:0] depth_channel_sel;
  logic             feat_valid;
  logic [CNT_W-1:0] out_h;
  logic [CNT_W-1:0] out_w;
  logic             busy;
  logic             layer_done;

  modport master (
    output start, input_size, channel, init_buffer_done, win_first, win_done, dsu_ready,
    input  init_buffer, depthwise_en, first_cycle, depth_channel_sel, feat_valid,
           out_h, out_w, busy, layer_done
  );

  modport slave (
    input  start, input_size, channel, init_buffer_done, win_first, win_done, dsu_ready,
    output init_buffer, depthwise_en, first_cycle, depth_channel_sel, feat_valid,
           out_h, out_w, busy, layer_done
  );
endinterface

// File: rtl/dw_pixel_counter.sv
// Raster-order output pixel counter (out_w fastest) with a last-pixel flag.
// Output side equals the unpadded input side, so bounds compare against size-1.
module dw_pixel_counter
  import dw_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic [CNT_W-1:0] size,
  output logic [CNT_W-1:0] out_h,
  output logic [CNT_W-1:0] out_w,
  output logic             last_pixel
);

  logic [CNT_W-1:0] size_m1;

  assign size_m1    = size - CNT_W'(1);
  assign last_pixel = (out_h == size_m1) && (out_w == size_m1);

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_h <= '0;
      out_w <= '0;
    end else if (clear) begin
      out_h <= '0;
      out_w <= '0;
    end else if (advance) begin
      if (out_w == size_m1) begin
        out_w <= '0;
        out_h <= out_h + CNT_W'(1);
      end else begin
        out_w <= out_w + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dw_window_scheduler.sv
// Depthwise pixel-window sequencer: fills the layer window, then steps output
// pixels in raster order and channel groups within each pixel toward the DSU.
module dw_window_scheduler
  import dw_pkg::*;
#(
  parameter int DATA_WIDTH          = 16,
  parameter int CHANNEL_PARALLELISM = 4,
  parameter int MAX_CHANNEL         = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  dw_window_scheduler_if.slave bus
);

  if (DATA_WIDTH < 1 || CHANNEL_PARALLELISM < 1 || MAX_CHANNEL > 255) begin : g_bad_params
    $error("dw_window_scheduler: illegal parameter set");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] size_q;
  logic [CNT_W-1:0] chan_q;
  logic [CNT_W-1:0] sel_q;
  logic             seen_low_q;
  logic             feat_valid_q;

  logic             accept;
  logic             last_grp;
  logic             last_pixel;
  logic             cnt_clear;
  logic             cnt_advance;
  logic             params_bad;

  assign accept     = (state_q == S_ISSUE) && bus.dsu_ready;
  assign last_grp   = last_group(sel_q, chan_q, CHANNEL_PARALLELISM);
  assign params_bad = (bus.channel == '0) || (bus.input_size == '0) ||
                      (bus.channel > CNT_W'(MAX_CHANNEL));

  dw_pixel_counter u_pixel_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear),
    .advance    (cnt_advance),
    .size       (size_q),
    .out_h      (bus.out_h),
    .out_w      (bus.out_w),
    .last_pixel (last_pixel)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_clear = 1'b1;
          state_d   = params_bad ? S_DONE : S_INIT;
        end
      end
      S_INIT:       state_d = S_WAIT_FILL;
      S_WAIT_FILL:  if (bus.init_buffer_done) state_d = S_WAIT_FIRST;
      S_WAIT_FIRST: if (bus.win_first)        state_d = S_ISSUE;
      S_ISSUE: begin
        if (accept && last_grp) begin
          if (last_pixel) begin
            state_d = S_DONE;
          end else begin
            cnt_advance = 1'b1;
            state_d     = S_WAIT_WIN;
          end
        end
      end
      // win_done still reflects the previous pixel on entry; only a low-then-high
      // sequence proves the window has actually moved on.
      S_WAIT_WIN:   if (seen_low_q && bus.win_done) state_d = S_ISSUE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      size_q       <= '0;
      chan_q       <= '0;
      sel_q        <= '0;
      seen_low_q   <= 1'b0;
      feat_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      feat_valid_q <= accept;

      if (state_q == S_IDLE && bus.start) begin
        size_q <= bus.input_size;
        chan_q <= bus.channel;
        sel_q  <= '0;
      end else if (accept) begin
        sel_q <= last_grp ? '0 : sel_q + CNT_W'(CHANNEL_PARALLELISM);
      end

      if (state_q != S_WAIT_WIN) seen_low_q <= 1'b0;
      else if (!bus.win_done)    seen_low_q <= 1'b1;
    end
  end

  assign bus.init_buffer       = (state_q == S_INIT);
  assign bus.depthwise_en      = accept && (sel_q == '0);
  assign bus.first_cycle       = accept && last_grp;
  assign bus.depth_channel_sel = sel_q;
  assign bus.feat_valid        = feat_valid_q;
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.layer_done        = (state_q == S_DONE);

endmodule

// File: tb/tb_dw_window_scheduler.sv
// Scoreboard bench for dw_window_scheduler: expected DSU beats are queued per
// layer, a monitor pops one per feat_valid and compares the issuing snapshot.
module tb_dw_window_scheduler;
  import dw_pkg::*;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] h;
    logic [7:0] w;
    logic       de;
    logic       fc;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dw_window_scheduler_if ifc ();

  dw_window_scheduler #(
    .DATA_WIDTH          (16),
    .CHANNEL_PARALLELISM (4),
    .MAX_CHANNEL         (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  beat_t exp_q[$];
  beat_t prev;
  bit    have_prev;
  int    n_vec, n_err;
  int    n_de, n_fc, n_ib, n_ld;
  bit    pix_end, stale;
  int    win_mode;
  bit    stall_en, stall_used;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " init_buffer"}, int'(ifc.init_buffer), 0);
    check({tag, " depthwise_en"}, int'(ifc.depthwise_en), 0);
    check({tag, " first_cycle"}, int'(ifc.first_cycle), 0);
    check({tag, " sel"}, int'(ifc.depth_channel_sel), 0);
    check({tag, " feat_valid"}, int'(ifc.feat_valid), 0);
    check({tag, " out_h"}, int'(ifc.out_h), 0);
    check({tag, " out_w"}, int'(ifc.out_w), 0);
    check({tag, " busy"}, int'(ifc.busy), 0);
    check({tag, " layer_done"}, int'(ifc.layer_done), 0);
  endtask

  // Monitor: one expected beat per feat_valid, compared with the previous
  // cycle's snapshot (the cycle in which that group was accepted).
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 1'b0;
      end else begin
        if (ifc.feat_valid) begin
          check("beat expected", int'(have_prev && exp_q.size() != 0), 1);
          if (have_prev && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat sel", int'(prev.sel), int'(e.sel));
            check("beat out_h", int'(prev.h), int'(e.h));
            check("beat out_w", int'(prev.w), int'(e.w));
            check("beat depthwise_en", int'(prev.de), int'(e.de));
            check("beat first_cycle", int'(prev.fc), int'(e.fc));
          end
        end
        if (ifc.depthwise_en) begin
          n_de++;
          check("issue while win_done stale", int'(stale), 0);
        end
        if (ifc.first_cycle) begin
          n_fc++;
          pix_end = 1'b1;
        end
        if (ifc.init_buffer) n_ib++;
        if (ifc.layer_done)  n_ld++;
        if (!ifc.dsu_ready) begin
          check("stall sel hold", int'(ifc.depth_channel_sel), 8);
          check("stall depthwise_en", int'(ifc.depthwise_en), 0);
          check("stall first_cycle", int'(ifc.first_cycle), 0);
        end
        prev.sel  = ifc.depth_channel_sel;
        prev.h    = ifc.out_h;
        prev.w    = ifc.out_w;
        prev.de   = ifc.depthwise_en;
        prev.fc   = ifc.first_cycle;
        have_prev = 1'b1;
      end
    end
  end

  // Layer/pixel window and DSU model, driven just after each rising edge.
  initial begin
    int fill_cnt, first_cnt, done_cnt, stall_cnt;
    bit rise_pending;
    fill_cnt = 0; first_cnt = 0; done_cnt = 0; stall_cnt = 0; rise_pending = 0;
    ifc.start = 1'b0; ifc.input_size = '0; ifc.channel = '0;
    ifc.init_buffer_done = 1'b0; ifc.win_first = 1'b0;
    ifc.win_done = 1'b0; ifc.dsu_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        fill_cnt = 0; first_cnt = 0; done_cnt = 0; stall_cnt = 0; rise_pending = 0;
        pix_end = 1'b0; stale = 1'b0;
        ifc.init_buffer_done = 1'b0; ifc.win_first = 1'b0;
        ifc.win_done = 1'b0; ifc.dsu_ready = 1'b1;
        continue;
      end
      ifc.init_buffer_done = 1'b0;
      ifc.win_first        = 1'b0;
      if (fill_cnt != 0) begin
        fill_cnt--;
        if (fill_cnt == 0) begin
          ifc.init_buffer_done = 1'b1;
          first_cnt = 2;
        end
      end else if (first_cnt != 0) begin
        first_cnt--;
        if (first_cnt == 0) ifc.win_first = 1'b1;
      end
      if (ifc.init_buffer) fill_cnt = 4;

      // mode 0: done drops then rises 3 cycles later; mode 1: done stays high
      // (stale) for 6 cycles, drops one cycle, then rises.
      if (pix_end) begin
        pix_end = 1'b0;
        if (win_mode == 0) begin
          ifc.win_done = 1'b0;
        end else begin
          ifc.win_done = 1'b1;
          stale = 1'b1;
        end
        done_cnt = (win_mode == 0) ? 3 : 6;
      end else if (rise_pending) begin
        rise_pending = 1'b0;
        ifc.win_done = 1'b1;
      end else if (done_cnt != 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          if (win_mode == 0) begin
            ifc.win_done = 1'b1;
          end else begin
            ifc.win_done = 1'b0;
            stale = 1'b0;
            rise_pending = 1'b1;
          end
        end
      end

      if (stall_cnt != 0) begin
        stall_cnt--;
        if (stall_cnt == 0) ifc.dsu_ready = 1'b1;
      end else if (stall_en && !stall_used && ifc.busy && ifc.depth_channel_sel == 8'd8) begin
        ifc.dsu_ready = 1'b0;
        stall_cnt = 5;
        stall_used = 1'b1;
      end
    end
  end

  task automatic push_layer(input int size, input int ch);
    beat_t b;
    int groups;
    groups = ch / 4;
    exp_q.delete();
    if (size == 0 || ch == 0) return;
    for (int h = 0; h < size; h++)
      for (int w = 0; w < size; w++)
        for (int g = 0; g < groups; g++) begin
          b.sel = 8'(g * 4);
          b.h   = 8'(h);
          b.w   = 8'(w);
          b.de  = (g == 0);
          b.fc  = (g == groups - 1);
          exp_q.push_back(b);
        end
  endtask

  task automatic pulse_start(input int size, input int ch);
    @(posedge clk); #1;
    ifc.input_size = 8'(size);
    ifc.channel    = 8'(ch);
    ifc.start      = 1'b1;
    @(posedge clk); #1;
    ifc.start      = 1'b0;
  endtask

  task automatic run_layer(input int size, input int ch, input int mode,
                           input bit stall, input bit busy_start);
    int pix;
    bit bad;
    bad = (size == 0 || ch == 0);
    pix = bad ? 0 : size * size;
    n_de = 0; n_fc = 0; n_ib = 0; n_ld = 0;
    win_mode = mode; stall_en = stall; stall_used = 1'b0;
    push_layer(size, ch);
    pulse_start(size, ch);
    check("init_buffer after start", int'(ifc.init_buffer), bad ? 0 : 1);
    check("layer_done after start", int'(ifc.layer_done), bad ? 1 : 0);
    if (busy_start) begin
      repeat (3) @(posedge clk);
      #1;
      ifc.channel = '0;
      ifc.start   = 1'b1;
      @(posedge clk); #1;
      ifc.start   = 1'b0;
      ifc.channel = 8'(ch);
    end
    for (int i = 0; i < 4000; i++) begin
      if (n_ld != 0) break;
      @(posedge clk);
    end
    repeat (10) @(posedge clk);
    check("layer_done count", n_ld, 1);
    check("init_buffer count", n_ib, bad ? 0 : 1);
    check("depthwise_en count", n_de, pix);
    check("first_cycle count", n_fc, pix);
    check("beats outstanding", exp_q.size(), 0);
    check("busy after layer", int'(ifc.busy), 0);
    exp_q.delete();
  endtask

  initial begin
    bit found;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_vec = 0; n_err = 0;
    win_mode = 0; stall_en = 1'b0; stall_used = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    run_layer(3, 8, 0, 1'b0, 1'b0);   // baseline: 9 pixels x 2 groups
    run_layer(3, 4, 0, 1'b0, 1'b0);   // single group: de and fc coincide
    run_layer(2, 16, 0, 1'b1, 1'b0);  // 5-cycle DSU stall at sel=8
    run_layer(2, 8, 1, 1'b0, 1'b0);   // win_done held high across pixels
    run_layer(2, 4, 0, 1'b0, 1'b1);   // start while busy is ignored
    run_layer(3, 0, 0, 1'b0, 1'b0);   // zero channels: straight to DONE
    run_layer(1, 8, 0, 1'b0, 1'b0);   // 1x1 map: first pixel is last

    // Reset while issuing pixel (1,2), then a clean layer.
    win_mode = 0; stall_en = 1'b0;
    push_layer(3, 8);
    pulse_start(3, 8);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ifc.depthwise_en && ifc.out_h == 8'd1 && ifc.out_w == 8'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("reached pixel (1,2)", int'(found), 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_zero("mid-layer reset");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    run_layer(3, 8, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
